// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch port (if_*)
// and the data port (dm_*). One access in flight at a time. The data port wins
// ties, but a streak counter hands the memory to fetch after STARVE_LIMIT
// back-to-back data grants so instruction fetch is never starved.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ack_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_ack_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(MEM_LATENCY + 1);
  localparam int STK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STK_W-1:0]    streak_q, streak_d;
  logic                cmd_we_q, cmd_we_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ack_q, if_ack_d;
  logic                dm_ack_q, dm_ack_d;
  logic                dm_wins;

  // Data port wins unless fetch is also waiting and the data streak is used up.
  always_comb begin
    dm_wins = dm_req_i && (!if_req_i || (streak_q < STK_MAX));
  end

  // Next-state logic: arbitration, command launch, latency countdown, ack pulse.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    cmd_we_d    = cmd_we_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dm_wins) begin
          owner_d     = OWN_DM;
          cmd_we_d    = dm_we_i;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we_i;
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          streak_d    = if_req_i ? (streak_q + 1'b1) : '0;
          state_d     = S_ISSUE;
        end else if (if_req_i) begin
          owner_d     = OWN_IF;
          cmd_we_d    = 1'b0;
          mem_req_d   = 1'b1;
          mem_addr_d  = if_addr_i;
          streak_d    = '0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata_i;
            if_ack_d   = 1'b1;
          end else begin
            if (!cmd_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
            dm_ack_d = 1'b1;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        owner_d = OWN_NONE;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset drops any in-flight access without acking it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      cnt_q       <= '0;
      streak_q    <= '0;
      cmd_we_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      cmd_we_q    <= cmd_we_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_stall_o  = if_req_i & ~if_ack_q;
  assign dm_stall_o  = dm_req_i & ~dm_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a small word memory
// that answers reads exactly two cycles after the command strobe.
module tb_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int MEM_LATENCY  = 2;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_ack_o;
  logic              if_stall_o;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_ack_o;
  logic              dm_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata;

  logic              load_mem;
  logic [DATA_W-1:0] rd_stage;
  logic [DATA_W-1:0] mem_model [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_dm_rdata;
  } vec_t;

  vec_t vecs [8];

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .MEM_LATENCY(MEM_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata_o),
    .if_ack_o(if_ack_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Word memory: writes land on the strobe edge, read data shows up for exactly
  // one cycle, two cycles after the strobe; other cycles carry a poison value.
  always @(posedge clk) begin
    mem_rdata <= rd_stage;
    rd_stage  <= 32'h0BAD0BAD;
    if (load_mem) begin
      for (int i = 0; i < 1024; i++) begin
        mem_model[i] <= 32'hF00D0000 | 32'(i);
      end
      mem_model[16]  <= 32'hDEADBEEF;
      mem_model[17]  <= 32'h13000093;
      mem_model[32]  <= 32'h11112222;
    end else if (mem_req_o) begin
      if (mem_we_o) begin
        mem_model[mem_addr_o[11:2]] <= mem_wdata_o;
      end else begin
        rd_stage <= mem_model[mem_addr_o[11:2]];
      end
    end
  end

  // Hard stop in case something wedges the sequence below.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: test still running, expected finish");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    logic [1:0] own;
    own      = v.is_dm ? 2'b01 : 2'b10;
    if_req   = !v.is_dm;
    if_addr  = v.is_dm ? 32'h0 : v.addr;
    dm_req   = v.is_dm;
    dm_we    = v.we;
    dm_addr  = v.is_dm ? v.addr : 32'h0;
    dm_wdata = v.wdata;
    #1;
    checkOutput($sformatf("%s_stall_req", tag), 128'({if_stall_o, dm_stall_o}), 128'(own));
    tick();
    checkOutput($sformatf("%s_cmd", tag), 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
                128'({1'b1, v.we, v.addr, v.wdata}));
    checkOutput($sformatf("%s_issue", tag), 128'({if_ack_o, dm_ack_o, if_stall_o, dm_stall_o}),
                128'({2'b00, own}));
    tick();
    checkOutput($sformatf("%s_wait1", tag), 128'({mem_req_o, if_ack_o, dm_ack_o, if_stall_o, dm_stall_o}),
                128'({3'b000, own}));
    tick();
    checkOutput($sformatf("%s_wait2", tag), 128'({mem_req_o, if_ack_o, dm_ack_o, if_stall_o, dm_stall_o}),
                128'({3'b000, own}));
    tick();
    checkOutput($sformatf("%s_ack", tag), 128'({if_ack_o, dm_ack_o, if_stall_o, dm_stall_o}),
                128'({own, 2'b00}));
    checkOutput($sformatf("%s_if_rdata", tag), 128'(if_rdata_o), 128'(v.exp_if_rdata));
    checkOutput($sformatf("%s_dm_rdata", tag), 128'(dm_rdata_o), 128'(v.exp_dm_rdata));
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    checkOutput($sformatf("%s_idle", tag), 128'({mem_req_o, if_ack_o, dm_ack_o}), 128'(3'b000));
  endtask

  // Main sequence: reset, table vectors, then the multi-cycle corner cases.
  initial begin
    logic [6:0] got_if;
    logic [6:0] exp_if;
    int         grants;
    bit         done;
    vec_t       v;

    //          is_dm we    addr          wdata         exp_if_rdata  exp_dm_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h00000040, 32'h00000000, 32'hDEADBEEF, 32'h00000000};
    vecs[1] = '{1'b1, 1'b0, 32'h00000080, 32'h00000000, 32'hDEADBEEF, 32'h11112222};
    vecs[2] = '{1'b1, 1'b1, 32'h00000200, 32'hCAFEF00D, 32'hDEADBEEF, 32'h11112222};
    vecs[3] = '{1'b1, 1'b0, 32'h00000200, 32'h00000000, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 32'h00000044, 32'h00000000, 32'h13000093, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'h00000080, 32'h55AA55AA, 32'h13000093, 32'hCAFEF00D};
    vecs[6] = '{1'b1, 1'b0, 32'h00000080, 32'h00000000, 32'h13000093, 32'h55AA55AA};
    vecs[7] = '{1'b0, 1'b0, 32'h00000080, 32'h00000000, 32'h55AA55AA, 32'h55AA55AA};

    // Reset held two cycles with random inputs.
    load_mem = 1'b1;
    rst      = 1'b1;
    if_req   = 1'($urandom_range(0, 1));
    if_addr  = $urandom();
    dm_req   = 1'($urandom_range(0, 1));
    dm_we    = 1'($urandom_range(0, 1));
    dm_addr  = $urandom();
    dm_wdata = $urandom();
    for (int c = 0; c < 2; c++) begin
      tick();
      load_mem = 1'b0;
      checkOutput($sformatf("rst%0d_ctrl", c),
                  128'({if_ack_o, dm_ack_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}), 128'(0));
      checkOutput($sformatf("rst%0d_rdata", c), 128'({if_rdata_o, dm_rdata_o}), 128'(0));
      if_req = 1'($urandom_range(0, 1));
      dm_req = 1'($urandom_range(0, 1));
    end
    rst      = 1'b0;
    if_req   = 1'b0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    if_addr  = 32'h0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;

    // Single-port transactions back to back at the maximum rate.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Simultaneous fetch and data write: data first, fetch right after.
    if_req   = 1'b1;
    if_addr  = 32'h00000044;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h00000100;
    dm_wdata = 32'h12345678;
    #1;
    checkOutput("both_stall", 128'({if_stall_o, dm_stall_o}), 128'(2'b11));
    tick();
    checkOutput("both_dm_cmd", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
                128'({1'b1, 1'b1, 32'h00000100, 32'h12345678}));
    tick();
    tick();
    checkOutput("both_no_early_ack", 128'({if_ack_o, dm_ack_o}), 128'(2'b00));
    tick();
    checkOutput("both_dm_ack", 128'({if_ack_o, dm_ack_o, if_stall_o, dm_stall_o}), 128'(4'b0110));
    checkOutput("both_dm_rdata_kept", 128'(dm_rdata_o), 128'(32'h55AA55AA));
    dm_req = 1'b0;
    dm_we  = 1'b0;
    tick();
    checkOutput("both_gap", 128'({mem_req_o, if_stall_o}), 128'(2'b01));
    tick();
    checkOutput("both_if_cmd", 128'({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o}),
                128'({1'b1, 1'b0, 32'h00000044, 32'h00000000}));
    tick();
    tick();
    tick();
    checkOutput("both_if_ack", 128'({if_ack_o, dm_ack_o, if_stall_o, dm_stall_o}), 128'(4'b1000));
    checkOutput("both_if_rdata", 128'(if_rdata_o), 128'(32'h13000093));
    if_req = 1'b0;
    tick();

    // Starvation guard: continuous data reads with a fetch held pending.
    exp_if   = 7'b0010000;
    got_if   = '0;
    grants   = 0;
    done     = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h00000300;
    dm_req   = 1'b1;
    dm_we    = 1'b0;
    dm_addr  = 32'h00000400;
    dm_wdata = 32'h0;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      if (mem_req_o && grants < 7) begin
        got_if[grants] = (mem_addr_o == if_addr);
        grants++;
      end
      if (if_ack_o || dm_ack_o) begin
        if (grants >= 7) begin
          if_req = 1'b0;
          dm_req = 1'b0;
          done   = 1'b1;
        end else if (dm_ack_o) begin
          dm_addr = dm_addr + 32'h4;
        end else begin
          if_addr = if_addr + 32'h4;
        end
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    checkOutput("starve_done", 128'({done, 32'(grants)}), 128'({1'b1, 32'd7}));
    for (int i = 0; i < 7; i++) begin
      checkOutput($sformatf("starve_grant%0d_is_if", i), 128'(got_if[i]), 128'(exp_if[i]));
    end
    tick();

    // Reset while a data read is waiting on memory: no ack, rdata cleared.
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h00000080;
    tick();
    checkOutput("rstmid_cmd", 128'({mem_req_o, mem_addr_o}), 128'({1'b1, 32'h00000080}));
    tick();
    rst = 1'b1;
    tick();
    checkOutput("rstmid_ctrl", 128'({if_ack_o, dm_ack_o, mem_req_o, mem_we_o, mem_addr_o}), 128'(0));
    checkOutput("rstmid_rdata", 128'({if_rdata_o, dm_rdata_o}), 128'(0));
    rst    = 1'b0;
    dm_req = 1'b0;
    v = '{1'b0, 1'b0, 32'h00000040, 32'h00000000, 32'hDEADBEEF, 32'h00000000};
    applyStimulus(v, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
